// File: rtl/countdown_4b.sv
// countdown_4b: loadable down-counter with pause, one-shot / auto-reload
// operation and a registered one-cycle terminal-count pulse.
module countdown_4b #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done,
  output logic             paused
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] reload;

  // State, count, reload register and tc pulse; priority is reset, load, enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      reload <= '0;
      tc     <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (load) begin
        count  <= load_value;
        reload <= load_value;
        state  <= (load_value != '0) ? RUN : IDLE;
      end else begin
        unique case (state)
          RUN, PAUSE: begin
            if (enable) begin
              if (count > WIDTH'(1)) begin
                count <= count - WIDTH'(1);
                state <= RUN;
              end else if (count == WIDTH'(1)) begin
                tc <= 1'b1;
                if (auto_reload) begin
                  count <= reload;
                  state <= RUN;
                end else begin
                  count <= '0;
                  state <= DONE;
                end
              end else begin
                // count of 0 while running cannot arise from load; park safely
                count <= '0;
                state <= IDLE;
              end
            end else begin
              state <= PAUSE;
            end
          end
          IDLE, DONE: begin
            state <= state;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  // Status flags decoded from the registered state only.
  always_comb begin
    busy   = (state == RUN) || (state == PAUSE);
    done   = (state == DONE);
    paused = (state == PAUSE);
  end

endmodule

// File: tb/tb_countdown_4b.sv
// tb_countdown_4b: scoreboard bench for countdown_4b; each scenario task
// queues the expected post-edge outputs alongside the sampled ones.
module tb_countdown_4b;

  typedef struct packed {
    logic [3:0] cnt;
    logic       tc;
    logic       busy;
    logic       done;
    logic       paused;
  } obs_t;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       load;
  logic [3:0] load_value;
  logic       auto_reload;
  logic [3:0] count;
  logic       tc;
  logic       busy;
  logic       done;
  logic       paused;

  int unsigned checks;
  int unsigned errors;

  obs_t exp_q[$];
  obs_t obs_q[$];

  countdown_4b #(.WIDTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .load       (load),
    .load_value (load_value),
    .auto_reload(auto_reload),
    .count      (count),
    .tc         (tc),
    .busy       (busy),
    .done       (done),
    .paused     (paused)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t mk(input logic [3:0] c, input logic t, input logic b,
                              input logic d, input logic p);
    obs_t o;
    o.cnt = c; o.tc = t; o.busy = b; o.done = d; o.paused = p;
    return o;
  endfunction

  // Drive one cycle of inputs, queue the expectation, sample 1 ns after the edge.
  task automatic drive(input logic r, input logic l, input logic [3:0] lv,
                       input logic e, input logic a, input obs_t ex);
    reset = r; load = l; load_value = lv; enable = e; auto_reload = a;
    exp_q.push_back(ex);
    @(posedge clk);
    #1;
    obs_q.push_back(mk(count, tc, busy, done, paused));
  endtask

  task automatic test_reset();
    obs_t e, o;
    int n = 0;
    drive(1, 1, 4'd9, 1, 0, mk(4'd0, 0, 0, 0, 0));
    drive(0, 1, 4'd9, 0, 0, mk(4'd9, 0, 1, 0, 0));
    drive(1, 1, 4'd9, 1, 1, mk(4'd0, 0, 0, 0, 0));
    drive(0, 0, 4'd9, 1, 0, mk(4'd0, 0, 0, 0, 0));
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset[%0d]: got cnt=%0d tc=%b busy=%b done=%b paused=%b, want cnt=%0d tc=%b busy=%b done=%b paused=%b",
                 n, o.cnt, o.tc, o.busy, o.done, o.paused, e.cnt, e.tc, e.busy, e.done, e.paused);
      end
      n++;
    end
  endtask

  task automatic test_oneshot();
    obs_t e, o;
    int n = 0;
    drive(0, 1, 4'd5, 1, 0, mk(4'd5, 0, 1, 0, 0));
    for (int i = 4; i >= 1; i--) drive(0, 0, 4'd0, 1, 0, mk(4'(i), 0, 1, 0, 0));
    drive(0, 0, 4'd0, 1, 0, mk(4'd0, 1, 0, 1, 0));
    for (int i = 0; i < 3; i++) drive(0, 0, 4'd0, 1, 0, mk(4'd0, 0, 0, 1, 0));
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL oneshot[%0d]: got cnt=%0d tc=%b busy=%b done=%b paused=%b, want cnt=%0d tc=%b busy=%b done=%b paused=%b",
                 n, o.cnt, o.tc, o.busy, o.done, o.paused, e.cnt, e.tc, e.busy, e.done, e.paused);
      end
      n++;
    end
  endtask

  task automatic test_pause();
    obs_t e, o;
    int n = 0;
    drive(0, 1, 4'd9, 0, 0, mk(4'd9, 0, 1, 0, 0));
    drive(0, 0, 4'd0, 1, 0, mk(4'd8, 0, 1, 0, 0));
    drive(0, 0, 4'd0, 1, 0, mk(4'd7, 0, 1, 0, 0));
    drive(0, 0, 4'd0, 1, 0, mk(4'd6, 0, 1, 0, 0));
    drive(0, 0, 4'd0, 0, 0, mk(4'd6, 0, 1, 0, 1));
    drive(0, 0, 4'd0, 0, 1, mk(4'd6, 0, 1, 0, 1));
    drive(0, 0, 4'd0, 1, 0, mk(4'd5, 0, 1, 0, 0));
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL pause[%0d]: got cnt=%0d tc=%b busy=%b done=%b paused=%b, want cnt=%0d tc=%b busy=%b done=%b paused=%b",
                 n, o.cnt, o.tc, o.busy, o.done, o.paused, e.cnt, e.tc, e.busy, e.done, e.paused);
      end
      n++;
    end
  endtask

  task automatic test_autoreload();
    obs_t e, o;
    int n = 0;
    drive(0, 1, 4'd3, 0, 1, mk(4'd3, 0, 1, 0, 0));
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 4'd0, 1, 1, mk(4'd2, 0, 1, 0, 0));
      drive(0, 0, 4'd0, 1, 1, mk(4'd1, 0, 1, 0, 0));
      drive(0, 0, 4'd0, 1, 1, mk(4'd3, 1, 1, 0, 0));
    end
    // auto_reload only matters at the count==1 decrement
    drive(0, 0, 4'd0, 1, 0, mk(4'd2, 0, 1, 0, 0));
    drive(0, 0, 4'd0, 1, 0, mk(4'd1, 0, 1, 0, 0));
    drive(0, 0, 4'd0, 1, 1, mk(4'd3, 1, 1, 0, 0));
    drive(0, 0, 4'd0, 1, 1, mk(4'd2, 0, 1, 0, 0));
    drive(0, 0, 4'd0, 1, 1, mk(4'd1, 0, 1, 0, 0));
    drive(0, 0, 4'd0, 1, 0, mk(4'd0, 1, 0, 1, 0));
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL autoreload[%0d]: got cnt=%0d tc=%b busy=%b done=%b paused=%b, want cnt=%0d tc=%b busy=%b done=%b paused=%b",
                 n, o.cnt, o.tc, o.busy, o.done, o.paused, e.cnt, e.tc, e.busy, e.done, e.paused);
      end
      n++;
    end
  endtask

  task automatic test_reload_mid();
    obs_t e, o;
    int n = 0;
    drive(0, 1, 4'd4, 0, 0, mk(4'd4, 0, 1, 0, 0));
    drive(0, 0, 4'd0, 1, 0, mk(4'd3, 0, 1, 0, 0));
    drive(0, 0, 4'd0, 1, 0, mk(4'd2, 0, 1, 0, 0));
    drive(0, 1, 4'd7, 1, 0, mk(4'd7, 0, 1, 0, 0));
    drive(0, 0, 4'd0, 1, 0, mk(4'd6, 0, 1, 0, 0));
    drive(0, 1, 4'd0, 1, 1, mk(4'd0, 0, 0, 0, 0));
    drive(0, 0, 4'd0, 1, 1, mk(4'd0, 0, 0, 0, 0));
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reload_mid[%0d]: got cnt=%0d tc=%b busy=%b done=%b paused=%b, want cnt=%0d tc=%b busy=%b done=%b paused=%b",
                 n, o.cnt, o.tc, o.busy, o.done, o.paused, e.cnt, e.tc, e.busy, e.done, e.paused);
      end
      n++;
    end
  endtask

  task automatic test_reset_mid();
    obs_t e, o;
    int n = 0;
    drive(0, 1, 4'd2, 0, 1, mk(4'd2, 0, 1, 0, 0));
    drive(0, 0, 4'd0, 1, 1, mk(4'd1, 0, 1, 0, 0));
    drive(1, 0, 4'd0, 1, 1, mk(4'd0, 0, 0, 0, 0));
    drive(0, 0, 4'd0, 1, 1, mk(4'd0, 0, 0, 0, 0));
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset_mid[%0d]: got cnt=%0d tc=%b busy=%b done=%b paused=%b, want cnt=%0d tc=%b busy=%b done=%b paused=%b",
                 n, o.cnt, o.tc, o.busy, o.done, o.paused, e.cnt, e.tc, e.busy, e.done, e.paused);
      end
      n++;
    end
  endtask

  task automatic test_full_range();
    obs_t e, o;
    int n = 0;
    drive(0, 1, 4'd15, 0, 0, mk(4'd15, 0, 1, 0, 0));
    for (int i = 14; i >= 1; i--) drive(0, 0, 4'd0, 1, 0, mk(4'(i), 0, 1, 0, 0));
    drive(0, 0, 4'd0, 1, 0, mk(4'd0, 1, 0, 1, 0));
    drive(0, 0, 4'd0, 1, 1, mk(4'd0, 0, 0, 1, 0));
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL full_range[%0d]: got cnt=%0d tc=%b busy=%b done=%b paused=%b, want cnt=%0d tc=%b busy=%b done=%b paused=%b",
                 n, o.cnt, o.tc, o.busy, o.done, o.paused, e.cnt, e.tc, e.busy, e.done, e.paused);
      end
      n++;
    end
  endtask

  task automatic test_back_to_back();
    obs_t e, o;
    int n = 0;
    // load out of DONE, back-to-back loads, then a count of 1 straight to tc
    drive(0, 1, 4'd5, 0, 0, mk(4'd5, 0, 1, 0, 0));
    drive(0, 1, 4'd6, 1, 0, mk(4'd6, 0, 1, 0, 0));
    drive(0, 0, 4'd0, 1, 0, mk(4'd5, 0, 1, 0, 0));
    drive(0, 1, 4'd1, 1, 0, mk(4'd1, 0, 1, 0, 0));
    drive(0, 0, 4'd0, 0, 0, mk(4'd1, 0, 1, 0, 1));
    drive(0, 0, 4'd0, 1, 0, mk(4'd0, 1, 0, 1, 0));
    drive(0, 1, 4'd1, 0, 1, mk(4'd1, 0, 1, 0, 0));
    drive(0, 0, 4'd0, 1, 1, mk(4'd1, 1, 1, 0, 0));
    drive(0, 0, 4'd0, 1, 1, mk(4'd1, 1, 1, 0, 0));
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got cnt=%0d tc=%b busy=%b done=%b paused=%b, want cnt=%0d tc=%b busy=%b done=%b paused=%b",
                 n, o.cnt, o.tc, o.busy, o.done, o.paused, e.cnt, e.tc, e.busy, e.done, e.paused);
      end
      n++;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1; load = 1'b0; load_value = 4'd0; enable = 1'b0; auto_reload = 1'b0;
    test_reset();
    test_oneshot();
    test_pause();
    test_autoreload();
    test_reload_mid();
    test_reset_mid();
    test_full_range();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/countdown_4b.md
COUNTDOWN_4B -- requirements
Module: countdown_4b

Interface
REQ-001 SHALL provide parameter WIDTH, default 4, width of count, load_value and the internal reload register.
REQ-002 SHALL provide port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL provide port reset  input  1  synchronous, active-high reset; sampled only on the rising clk edge.
REQ-004 SHALL provide port enable  input  1  when high in RUN or PAUSE, decrements count by one per cycle.
REQ-005 SHALL provide port load  input  1  one-cycle strobe that captures load_value.
REQ-006 SHALL provide port load_value  input  WIDTH  start value, and reload value when auto_reload is set.
REQ-007 SHALL provide port auto_reload  input  1  level; when high, count restarts from the reload register at terminal count instead of stopping.
REQ-008 SHALL provide port count  output  WIDTH  registered current count.
REQ-009 SHALL provide port tc  output  1  registered terminal-count pulse, one cycle wide.
REQ-010 SHALL provide port busy  output  1  high in RUN or PAUSE.
REQ-011 SHALL provide port done  output  1  high in DONE.
REQ-012 SHALL provide port paused  output  1  high in PAUSE.

Function
REQ-013 SHALL implement the states IDLE, RUN, PAUSE and DONE; busy, done and paused SHALL be decoded from the registered state only.
REQ-014 Priority SHALL be: reset, then load, then enable.
REQ-015 On load with load_value != 0, in any state, SHALL set count and the reload register to load_value and enter RUN; tc SHALL be 0 in that cycle, with no decrement that cycle.
REQ-016 On load with load_value == 0 SHALL set count = 0 and reload = 0, enter IDLE, and not assert tc.
REQ-017 In RUN or PAUSE with enable=1 and count > 1, SHALL set count to count-1 and enter RUN.
REQ-018 In RUN or PAUSE with enable=1 and count == 1 and auto_reload=0, SHALL set count = 0 and tc = 1, and enter DONE.
REQ-019 In RUN or PAUSE with enable=1 and count == 1 and auto_reload=1, SHALL set count to the reload register and tc = 1, and remain in RUN; the period SHALL equal the reload value in cycles.
REQ-020 In RUN with enable=0 SHALL enter PAUSE with count held; tc SHALL stay 0.
REQ-021 In PAUSE with enable=0 SHALL hold count and state.
REQ-022 In IDLE and DONE, enable SHALL be ignored and count held (0 in DONE).
REQ-023 tc SHALL be 0 in every cycle not covered by REQ-018 or REQ-019.
REQ-024 count SHALL never underflow below 0 nor wrap to 2^WIDTH-1.
REQ-025 load_value = 2^WIDTH-1 SHALL count a full 2^WIDTH-1 enabled cycles to terminal count.
REQ-026 auto_reload SHALL be sampled only at the count == 1 decrement; changing it at other times SHALL have no effect.

Reset
REQ-027 On reset=1 at a rising clk edge, regardless of other inputs, SHALL set count = 0, reload = 0, tc = 0 and state = IDLE (busy = done = paused = 0) on that edge.
REQ-028 Reset asserted mid-RUN or in the same cycle as a terminal event SHALL suppress tc and any reload.
REQ-029 After reset release, the first load SHALL be accepted on the first edge with reset=0.

Verification
REQ-030 Reset test: reset=1 with load=1 and load_value=9 -> count=0, tc=0, busy=0, done=0 after the edge.
REQ-031 One-shot test: load 5, then enable held high, auto_reload=0 -> count 5,4,3,2,1,0; tc=1 only in the cycle count becomes 0; then done=1, busy=0, count stays 0 for 3 more cycles.
REQ-032 Pause test: load 9, enable for 3 cycles (count=6), enable low for 2 cycles -> paused=1, count=6, tc=0; enable again -> count 5 on the next edge, paused=0.
REQ-033 Auto-reload test: auto_reload=1, load 3, enable held 9 cycles -> count 2,1,3,2,1,3,2,1,3; tc on cycles 3, 6 and 9; never done.
REQ-034 Reload mid-count test: load 7 while count=2 in RUN -> count=7, tc=0, state RUN; load 0 in RUN -> count=0, IDLE, tc=0.
REQ-035 Reset mid-run test: count=1 in RUN, enable=1 and reset=1 on the same edge -> count=0, IDLE, tc=0.
